// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW result unpacker: FSM state encoding,
// record layout constants and default widths.
package dtw_pkg;

  // Default widths for the unpacker parameters
  localparam int DEFAULT_WIDTH      = 16;
  localparam int DEFAULT_DATA_WIDTH = 32;

  // Number of FIFO words per result record and the position of each word
  localparam int REC_WORDS = 3;
  localparam int WORD_QID  = 0;
  localparam int WORD_POS  = 1;
  localparam int WORD_MIN  = 2;

  // Unpacker FSM states; the first three collect words, HOLD presents the record
  typedef enum logic [1:0] {
    GET_QID = 2'd0,
    GET_POS = 2'd1,
    GET_MIN = 2'd2,
    HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/dtw_result_unpacker.sv
// DTW result unpacker: pops three-word records (qid, position, minval) from a
// first-word-fall-through result FIFO and presents them on a valid/ready port.
// Optional threshold filter enabled by defining DTW_RESULT_THRESH_EN; with it,
// records whose minval exceeds thresh are dropped and counted in n_dropped.
module dtw_result_unpacker
  import dtw_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rden,
  input  logic [WIDTH-1:0]      thresh,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [31:0]           rec_qid,
  output logic [31:0]           rec_position,
  output logic [WIDTH-1:0]      rec_minval,
  output logic                  busy,
  output logic                  err_frame,
  output logic [31:0]           n_records,
  output logic [31:0]           n_dropped
);

  state_t state;

  logic             pop;
  logic [WIDTH-1:0] min_word;
  logic             min_frame_bad;
  logic             keep;

  // Pop whenever a word is available and the FSM is still collecting; never during reset
  assign pop       = rst_n && !fifo_empty && (state != HOLD);
  assign fifo_rden = pop;
  assign busy      = (state != GET_QID);

  assign min_word      = fifo_data[WIDTH-1:0];
  assign min_frame_bad = |fifo_data[DATA_WIDTH-1:WIDTH];

`ifdef DTW_RESULT_THRESH_EN
  // Filter: a record is kept only when its cost does not exceed the threshold
  assign keep = (min_word <= thresh);
`else
  // No filter: every record is delivered and thresh is deliberately left unused
  logic unused_thresh;
  assign keep          = 1'b1;
  assign unused_thresh = ^thresh;
`endif

  // Record assembly FSM, output registers and counters; clear overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= GET_QID;
      rec_valid    <= 1'b0;
      rec_qid      <= '0;
      rec_position <= '0;
      rec_minval   <= '0;
      err_frame    <= 1'b0;
      n_records    <= '0;
      n_dropped    <= '0;
    end else if (clear) begin
      // Any word popped this cycle is consumed and discarded
      state     <= GET_QID;
      rec_valid <= 1'b0;
      err_frame <= 1'b0;
      n_records <= '0;
      n_dropped <= '0;
    end else begin
      case (state)
        GET_QID: begin
          if (pop) begin
            rec_qid <= fifo_data[31:0];
            state   <= GET_POS;
          end
        end
        GET_POS: begin
          if (pop) begin
            rec_position <= fifo_data[31:0];
            state        <= GET_MIN;
          end
        end
        GET_MIN: begin
          if (pop) begin
            // Malformed upper bits are flagged but the record still proceeds
            if (min_frame_bad) begin
              err_frame <= 1'b1;
            end
            if (keep) begin
              rec_minval <= min_word;
              rec_valid  <= 1'b1;
              state      <= HOLD;
            end else begin
              n_dropped <= n_dropped + 32'd1;
              state     <= GET_QID;
            end
          end
        end
        HOLD: begin
          if (rec_ready) begin
            rec_valid <= 1'b0;
            n_records <= n_records + 32'd1;
            state     <= GET_QID;
          end
        end
        default: state <= GET_QID;
      endcase
    end
  end

endmodule
